ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 10000, clock-low inhibit time in clk cycles (100 us at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000000, watchdog limit in clk cycles (20 ms at 100 MHz).
REQ-003 SHALL have port clk, input, 1, system clock; the block uses one clock.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port tx_data, input, 8, command byte to send to the keyboard.
REQ-006 SHALL have port tx_valid, input, 1, tx_data valid.
REQ-007 SHALL have port tx_ready, output, 1, high only in IDLE.
REQ-008 SHALL have port ps2_clk_i, input, 1, raw PS2_CLK line level.
REQ-009 SHALL have port ps2_data_i, input, 1, raw PS2_DATA line level.
REQ-010 SHALL have port ps2_clk_oe, output, 1, 1 = drive PS2_CLK low, 0 = release.
REQ-011 SHALL have port ps2_data_oe, output, 1, 1 = drive PS2_DATA low, 0 = release.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE; the PS/2 receiver ignores frames while busy.
REQ-013 SHALL have port tx_done, output, 1, one-cycle pulse when the device ACK is received.
REQ-014 SHALL have port tx_err, output, 1, one-cycle pulse on NACK or timeout.

Function
REQ-015 SHALL pass ps2_clk_i and ps2_data_i through 2-flop synchronizers; a falling edge is synchronized clk 1 then 0 on consecutive cycles.
REQ-016 SHALL accept a byte when tx_valid && tx_ready; tx_data is latched and the odd parity bit (~^tx_data) is computed on that same edge.
REQ-017 SHALL implement states IDLE, INHIBIT, RTS, BITS, ACK, WAIT_IDLE.
REQ-018 IDLE behaviour: both oe = 0, tx_ready = 1; on accept go to INHIBIT on the next cycle.
REQ-019 INHIBIT behaviour: ps2_clk_oe = 1, ps2_data_oe = 0 for exactly INHIBIT_CYCLES cycles, then go to RTS.
REQ-020 RTS behaviour: ps2_clk_oe = 1, ps2_data_oe = 1 (start bit) for exactly 1 cycle, then go to BITS.
REQ-021 BITS behaviour: ps2_clk_oe = 0; a 4-bit edge counter starts at 0; ps2_data_oe holds the start bit (1) until the first falling edge.
REQ-022 BITS edge handling: on falling edge k (1..8) ps2_data_oe = ~data[k-1] (LSB first); edge 9 drives ~parity; edge 10 releases data (stop bit = 1) and goes to ACK.
REQ-023 ACK behaviour: on the next falling edge sample synchronized data; 0 pulses tx_done, 1 pulses tx_err; either way go to WAIT_IDLE.
REQ-024 WAIT_IDLE behaviour: return to IDLE once synchronized clk and data are both 1 for 1 cycle.
REQ-025 SHALL run a watchdog counter that clears on entry to BITS and counts every cycle in BITS, ACK and WAIT_IDLE.
REQ-026 Watchdog expiry: when the counter reaches TIMEOUT_CYCLES-1, pulse tx_err, release both lines and go to IDLE; this takes priority over a coincident edge.
REQ-027 SHALL register all outputs; oe changes take effect 1 cycle after the triggering synchronized edge.
REQ-028 SHALL ignore tx_valid while busy; a request held through busy is accepted in the first IDLE cycle.
REQ-029 SHALL ignore falling edges in IDLE, INHIBIT and RTS.
REQ-030 SHALL never assert tx_done and tx_err in the same cycle.
REQ-031 Counter widths: $clog2 of the respective parameter, with no wrap before the compare.

Reset
REQ-032 On rst (sampled at the clk edge) SHALL go to IDLE with ps2_clk_oe = 0, ps2_data_oe = 0, tx_ready = 1, busy = 0, tx_done = 0, tx_err = 0, all counters = 0.
REQ-033 rst mid-frame SHALL release both lines on the next cycle; the partial frame is dropped with no tx_err pulse.
REQ-034 rst SHALL override a coincident tx_valid accept.

Verification
REQ-035 Scenario: rst held 2 cycles -> oe = 00, tx_ready = 1, busy = 0, no pulses.
REQ-036 Scenario: send 0xED with a device model that ACKs -> clk_oe high for 10000 cycles; line sampled at device rising edges = 0 | 1,0,1,1,0,1,1,1 | parity 1 | stop 1; ACK low -> single tx_done pulse, then IDLE.
REQ-037 Scenario: send 0xF4 with the device holding data high at edge 11 -> data bits 0,0,1,0,1,1,1,1, parity 0; tx_err pulses once, tx_done = 0.
REQ-038 Scenario: send 0xFF with the device never clocking -> exactly TIMEOUT_CYCLES cycles after entering BITS, tx_err pulses, oe = 00, tx_ready = 1.
REQ-039 Scenario: rst asserted after the 4th falling edge of a 0x00 send -> oe = 00 next cycle, no tx_err, and a new 0x01 send then completes with parity 0.
REQ-040 Scenario: tx_valid held high across a 0xED frame with tx_data changed mid-frame -> frame bits stay 0xED; the second byte is accepted only after WAIT_IDLE.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Inhibits the bus, issues request-to-send, then shifts one command byte
// (LSB first, odd parity, stop) on device-generated clock falling edges and
// checks the device acknowledge. A watchdog aborts a stalled frame.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_RTS       = 3'd2;
  localparam logic [2:0] S_BITS      = 3'd3;
  localparam logic [2:0] S_ACK       = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  // Control state
  logic [2:0]       state_q, state_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic [3:0]       edge_cnt_q, edge_cnt_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  // Line synchronizers (s3 is the previous synchronized clock for edge detect)
  logic clk_s1_q, clk_s1_d;
  logic clk_s2_q, clk_s2_d;
  logic clk_s3_q, clk_s3_d;
  logic dat_s1_q, dat_s1_d;
  logic dat_s2_q, dat_s2_d;

  // Frame payload, latched on accept
  logic [7:0] byte_q, byte_d;
  logic       par_q, par_d;

  logic fall;
  logic accept;
  logic wd_expired;

  assign tx_ready    = ready_q;
  assign busy        = busy_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;

  // Next-state for synchronizers and edge detect
  always_comb begin
    clk_s1_d = ps2_clk_i;
    clk_s2_d = clk_s1_q;
    clk_s3_d = clk_s2_q;
    dat_s1_d = ps2_data_i;
    dat_s2_d = dat_s1_q;
    fall     = clk_s3_q & ~clk_s2_q;
  end

  // Frame sequencing, bit shifting, acknowledge check and watchdog
  always_comb begin
    state_d    = state_q;
    inh_cnt_d  = inh_cnt_q;
    wd_cnt_d   = wd_cnt_q;
    edge_cnt_d = edge_cnt_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    byte_d     = byte_q;
    par_d      = par_q;
    accept     = tx_valid & ready_q;
    wd_expired = (wd_cnt_q == WD_LAST);

    case (state_q)
      S_IDLE: begin
        clk_oe_d   = 1'b0;
        data_oe_d  = 1'b0;
        inh_cnt_d  = '0;
        wd_cnt_d   = '0;
        edge_cnt_d = '0;
        if (accept) begin
          byte_d   = tx_data;
          par_d    = ~^tx_data;
          clk_oe_d = 1'b1;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        clk_oe_d  = 1'b1;
        data_oe_d = 1'b0;
        if (inh_cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = S_RTS;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end
      S_RTS: begin
        // Release the clock but keep the start bit driven into BITS
        clk_oe_d   = 1'b0;
        data_oe_d  = 1'b1;
        edge_cnt_d = '0;
        wd_cnt_d   = '0;
        state_d    = S_BITS;
      end
      S_BITS, S_ACK, S_WAIT_IDLE: begin
        if (wd_expired) begin
          err_d     = 1'b1;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          wd_cnt_d  = '0;
          state_d   = S_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
          if (state_q == S_BITS) begin
            if (fall) begin
              edge_cnt_d = edge_cnt_q + 4'd1;
              if (edge_cnt_q < 4'd8) begin
                data_oe_d = ~byte_q[edge_cnt_q[2:0]];
              end else if (edge_cnt_q == 4'd8) begin
                data_oe_d = ~par_q;
              end else begin
                data_oe_d = 1'b0;
                state_d   = S_ACK;
              end
            end
          end else if (state_q == S_ACK) begin
            if (fall) begin
              done_d  = ~dat_s2_q;
              err_d   = dat_s2_q;
              state_d = S_WAIT_IDLE;
            end
          end else begin
            if (clk_s2_q && dat_s2_q) begin
              state_d = S_IDLE;
            end
          end
        end
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = ~ready_d;
  end

  // Control and synchronizer registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      inh_cnt_q  <= '0;
      wd_cnt_q   <= '0;
      edge_cnt_q <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_s3_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      inh_cnt_q  <= inh_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      clk_s3_q   <= clk_s3_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
    end
  end

  // Payload registers; only meaningful after an accept, so no reset
  always_ff @(posedge clk) begin
    byte_q <= byte_d;
    par_q  <= par_d;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 300;
  localparam int H   = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       tx_done;
  logic       tx_err;

  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;

  // Open-drain bus: either side may pull low
  assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_i = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int   done_cnt  = 0;
  int   err_cnt   = 0;
  int   both_cnt  = 0;
  int   inh_cnt   = 0;
  int   ready_cnt = 0;
  int   bits_cyc  = 0;
  int   err_cyc   = 0;
  logic oe_prev   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling system clock edge
  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (tx_done && tx_err) both_cnt <= both_cnt + 1;
    if (ps2_clk_oe && !ps2_data_oe) inh_cnt <= inh_cnt + 1;
    if (tx_ready) ready_cnt <= ready_cnt + 1;
    if (oe_prev && !ps2_clk_oe) bits_cyc <= cyc;
    oe_prev <= ps2_clk_oe;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic dev_wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!ps2_clk_oe && ps2_data_oe) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  // Generate n clock pulses; sample the data line before the first fall and at each rise
  task automatic dev_bits(input int n, output logic [10:0] fr);
    fr = '0;
    tick(4);
    fr[0] = ps2_data_i;
    for (int k = 1; k <= n; k++) begin
      dev_clk = 1'b0;
      tick(H);
      dev_clk = 1'b1;
      tick(1);
      fr[k] = ps2_data_i;
      tick(H - 1);
    end
  endtask

  task automatic dev_ack(input logic ack);
    dev_data = ~ack;
    tick(2);
    dev_clk = 1'b0;
    tick(H);
    dev_clk = 1'b1;
    tick(2);
    dev_data = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit          ok;
    logic [10:0] fr;
    int          d0, e0, i0, r0;

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tick(2);
    chk("rst_clk_oe",  ps2_clk_oe,  0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_ready",   tx_ready,    1);
    chk("rst_busy",    busy,        0);
    chk("rst_done",    tx_done,     0);
    chk("rst_err",     tx_err,      0);
    rst = 1'b0;
    tick(3);

    // 0xED acknowledged by the device
    d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
    send_byte(8'hED);
    chk("ed_busy",  busy,     1);
    chk("ed_ready", tx_ready, 0);
    dev_wait_start(ok);
    chk("ed_start", ok, 1);
    dev_bits(10, fr);
    dev_ack(1'b1);
    tick(6);
    chk("ed_frame",   fr,               11'h7DA);
    chk("ed_inhibit", inh_cnt - i0,     INH);
    chk("ed_done",    done_cnt - d0,    1);
    chk("ed_err",     err_cnt - e0,     0);
    chk("ed_both",    both_cnt,         0);
    chk("ed_idle_rdy", tx_ready,        1);
    chk("ed_idle_bsy", busy,            0);

    // 0xF4 with device NACK
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hF4);
    dev_wait_start(ok);
    chk("f4_start", ok, 1);
    dev_bits(10, fr);
    dev_ack(1'b0);
    tick(6);
    chk("f4_frame", fr,            11'h5E8);
    chk("f4_done",  done_cnt - d0, 0);
    chk("f4_err",   err_cnt - e0,  1);
    chk("f4_ready", tx_ready,      1);

    // 0xFF with a silent device: watchdog
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hFF);
    ok = 1'b0;
    for (int i = 0; i < INH + TMO + 50; i++) begin
      if (tx_err) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    chk("tmo_seen",    ok,          1);
    chk("tmo_clk_oe",  ps2_clk_oe,  0);
    chk("tmo_data_oe", ps2_data_oe, 0);
    chk("tmo_ready",   tx_ready,    1);
    tick(2);
    chk("tmo_delay", err_cyc - bits_cyc, TMO);
    chk("tmo_done",  done_cnt - d0,      0);
    chk("tmo_err",   err_cnt - e0,       1);
    tick(3);

    // Reset after the 4th falling edge of a 0x00 send, then a clean 0x01
    e0 = err_cnt;
    send_byte(8'h00);
    dev_wait_start(ok);
    chk("rm_start", ok, 1);
    dev_bits(3, fr);
    dev_clk = 1'b0;
    tick(6);
    chk("rm_bit3_drive", ps2_data_oe, 1);
    rst = 1'b1;
    tick(1);
    chk("rm_clk_oe",  ps2_clk_oe,  0);
    chk("rm_data_oe", ps2_data_oe, 0);
    chk("rm_busy",    busy,        0);
    rst = 1'b0;
    dev_clk = 1'b1;
    tick(5);
    chk("rm_no_err", err_cnt - e0, 0);
    d0 = done_cnt;
    send_byte(8'h01);
    dev_wait_start(ok);
    chk("01_start", ok, 1);
    dev_bits(10, fr);
    dev_ack(1'b1);
    tick(6);
    chk("01_frame", fr,            11'h402);
    chk("01_done",  done_cnt - d0, 1);

    // tx_valid held across a frame with data changed mid-frame
    d0 = done_cnt;
    tx_data  = 8'hED;
    tx_valid = 1'b1;
    tick(1);
    tx_data = 8'h5A;
    r0 = ready_cnt;
    dev_wait_start(ok);
    chk("hold_start", ok, 1);
    dev_bits(10, fr);
    chk("hold_ready_busy", ready_cnt - r0, 0);
    dev_ack(1'b1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    chk("hold_ready_seen", ok, 1);
    tick(1);
    chk("hold_reaccept", busy, 1);
    tx_valid = 1'b0;
    chk("hold_frame1", fr, 11'h7DA);
    dev_wait_start(ok);
    chk("hold_start2", ok, 1);
    dev_bits(10, fr);
    dev_ack(1'b1);
    tick(6);
    chk("hold_frame2", fr,            11'h6B4);
    chk("hold_done",   done_cnt - d0, 2);
    chk("final_both",  both_cnt,      0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
